// File: rtl/enc_pkg.sv
// Shared types and helpers for the enc_prio_rr request encoder.
package enc_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

    // Ceiling log2 for tools that lack $clog2 in constant expressions.
    function automatic int enc_clog2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result = result + 1;
            v      = v >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/enc_prio_find.sv
// Combinational lowest-set-bit finder: returns the index of the lowest set bit and a found flag.
module enc_prio_find #(
    parameter int N = 32,
    parameter int W = 5
) (
    input  logic [N-1:0] vec,
    output logic [W-1:0] idx,
    output logic         found
);

    always_comb begin
        // NOTE: combinational logic uses blocking '=' with defaults first, so no latch is inferred
        // and later loop iterations (lower indices) override earlier ones.
        idx   = '0;
        found = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx   = W'(i);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/enc_prio_rr.sv
// Registered request encoder with fixed-priority / round-robin arbitration; holds each grant until ack.
module enc_prio_rr
    import enc_pkg::*;
#(
    parameter  int N = 32,
    localparam int W = enc_clog2(N)
) (
    input  logic         clock,
    input  logic         clear_n,
    input  logic [N-1:0] req,
    input  logic         mode,
    input  logic         ack,
    output logic         grant_valid,
    output logic [W-1:0] grant_idx,
    output logic [N-1:0] grant_onehot,
    output logic         err_multi
);

    state_e       state_q, state_d;
    logic [W-1:0] rr_ptr_q, rr_ptr_d;
    logic         grant_mode_q, grant_mode_d;
    logic         grant_valid_q, grant_valid_d;
    logic [W-1:0] grant_idx_q, grant_idx_d;
    logic [N-1:0] grant_onehot_q, grant_onehot_d;
    logic         err_multi_q, err_multi_d;

    logic [N-1:0] rr_mask;
    logic [W-1:0] masked_idx, raw_idx, winner_idx;
    logic         masked_found, raw_found;
    logic         multi_req;

    // Channels at or above the round-robin pointer.
    always_comb begin
        rr_mask = '0;
        for (int i = 0; i < N; i++) begin
            rr_mask[i] = (W'(i) >= rr_ptr_q);
        end
    end

    enc_prio_find #(.N(N), .W(W)) u_find_masked (
        .vec   (req & rr_mask),
        .idx   (masked_idx),
        .found (masked_found)
    );

    enc_prio_find #(.N(N), .W(W)) u_find_raw (
        .vec   (req),
        .idx   (raw_idx),
        .found (raw_found)
    );

    // Falling back to the unmasked search provides the wrap from N-1 to 0.
    assign winner_idx = (mode && masked_found) ? masked_idx : raw_idx;
    assign multi_req  = ((req & (req - N'(1))) != '0);

    always_comb begin
        state_d        = state_q;
        rr_ptr_d       = rr_ptr_q;
        grant_mode_d   = grant_mode_q;
        grant_valid_d  = grant_valid_q;
        grant_idx_d    = grant_idx_q;
        grant_onehot_d = grant_onehot_q;
        err_multi_d    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (raw_found) begin
                    state_d        = GRANT;
                    grant_mode_d   = mode;
                    grant_valid_d  = 1'b1;
                    grant_idx_d    = winner_idx;
                    grant_onehot_d = N'(1) << winner_idx;
                    err_multi_d    = multi_req;
                end
            end
            GRANT: begin
                if (ack) begin
                    state_d       = IDLE;
                    grant_valid_d = 1'b0;
                    // Only round-robin grants advance the pointer.
                    if (grant_mode_q) begin
                        rr_ptr_d = (grant_idx_q == W'(N - 1)) ? '0 : grant_idx_q + W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking '<=' so every flop samples pre-edge values.
        if (!clear_n) begin
            state_q        <= IDLE;
            rr_ptr_q       <= '0;
            grant_mode_q   <= 1'b0;
            grant_valid_q  <= 1'b0;
            grant_idx_q    <= '0;
            grant_onehot_q <= '0;
            err_multi_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            rr_ptr_q       <= rr_ptr_d;
            grant_mode_q   <= grant_mode_d;
            grant_valid_q  <= grant_valid_d;
            grant_idx_q    <= grant_idx_d;
            grant_onehot_q <= grant_onehot_d;
            err_multi_q    <= err_multi_d;
        end
    end

    assign grant_valid  = grant_valid_q;
    assign grant_idx    = grant_idx_q;
    assign grant_onehot = grant_onehot_q;
    assign err_multi    = err_multi_q;

endmodule

// File: tb/tb_enc_prio_rr.sv
// Directed bench for enc_prio_rr: a 32-channel and a 5-channel instance with hand-computed expectations.
module tb_enc_prio_rr;

    logic        clock;
    logic        clear_n;

    logic [31:0] req32;
    logic        mode32;
    logic        ack32;
    logic        gv32;
    logic [4:0]  idx32;
    logic [31:0] oh32;
    logic        err32;

    logic [4:0]  req5;
    logic        mode5;
    logic        ack5;
    logic        gv5;
    logic [2:0]  idx5;
    logic [4:0]  oh5;
    logic        err5;

    int total_checks;
    int failed_checks;

    enc_prio_rr #(.N(32)) dut32 (
        .clock        (clock),
        .clear_n      (clear_n),
        .req          (req32),
        .mode         (mode32),
        .ack          (ack32),
        .grant_valid  (gv32),
        .grant_idx    (idx32),
        .grant_onehot (oh32),
        .err_multi    (err32)
    );

    enc_prio_rr #(.N(5)) dut5 (
        .clock        (clock),
        .clear_n      (clear_n),
        .req          (req5),
        .mode         (mode5),
        .ack          (ack5),
        .grant_valid  (gv5),
        .grant_idx    (idx5),
        .grant_onehot (oh5),
        .err_multi    (err5)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        total_checks++;
        assert (observed === expected)
        else begin
            failed_checks++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Advance one rising edge and settle away from it before sampling.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check32(input string tag, input logic gv, input logic [4:0] idx,
                           input logic [31:0] oh, input logic err);
        check({tag, ".valid"}, 64'(gv32), 64'(gv));
        check({tag, ".idx"}, 64'(idx32), 64'(idx));
        check({tag, ".onehot"}, 64'(oh32), 64'(oh));
        check({tag, ".err"}, 64'(err32), 64'(err));
    endtask

    initial begin
        total_checks  = 0;
        failed_checks = 0;
        clear_n = 1'b0;
        req32 = '0; mode32 = 1'b0; ack32 = 1'b0;
        req5  = '0; mode5  = 1'b0; ack5  = 1'b0;

        // Reset state
        tick();
        tick();
        check32("reset", 1'b0, 5'd0, 32'h0, 1'b0);
        check("reset5.valid", 64'(gv5), 64'd0);
        check("reset5.onehot", 64'(oh5), 64'd0);
        clear_n = 1'b1;

        // Fixed priority, single request pulse
        mode32 = 1'b0; req32 = 32'h0000_0001;
        tick();
        req32 = '0;
        check32("fp_single", 1'b1, 5'd0, 32'h1, 1'b0);
        ack32 = 1'b1;
        tick();
        ack32 = 1'b0;
        check32("fp_single_rel", 1'b0, 5'd0, 32'h1, 1'b0);

        // Fixed priority, two requests: lowest wins, err_multi one cycle only
        req32 = 32'h8000_0010;
        tick();
        check32("fp_multi", 1'b1, 5'd4, 32'h10, 1'b1);
        tick();
        check32("fp_multi_hold", 1'b1, 5'd4, 32'h10, 1'b0);
        ack32 = 1'b1;
        tick();
        ack32 = 1'b0;
        check("fp_multi_rel.valid", 64'(gv32), 64'd0);
        tick();
        check32("fp_multi_again", 1'b1, 5'd4, 32'h10, 1'b1);
        req32 = '0; ack32 = 1'b1;
        tick();
        ack32 = 1'b0;
        check("fp_multi_again_rel.valid", 64'(gv32), 64'd0);

        // Round robin, all requests held: 0..31,0,1, one grant every two cycles
        mode32 = 1'b1; req32 = 32'hFFFF_FFFF;
        for (int k = 0; k < 34; k++) begin
            tick();
            check($sformatf("rr_all[%0d].valid", k), 64'(gv32), 64'd1);
            check($sformatf("rr_all[%0d].idx", k), 64'(idx32), 64'(k % 32));
            check($sformatf("rr_all[%0d].onehot", k), 64'(oh32), 64'(32'h1 << (k % 32)));
            ack32 = 1'b1;
            tick();
            ack32 = 1'b0;
            check($sformatf("rr_all[%0d].rel", k), 64'(gv32), 64'd0);
        end
        req32 = '0;

        // Round robin (pointer now 2): grant held after the request drops, mode change ignored
        req32 = 32'h0000_0100;
        tick();
        req32 = '0;
        check32("rr_hold", 1'b1, 5'd8, 32'h100, 1'b0);
        mode32 = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            check($sformatf("rr_hold[%0d].valid", k), 64'(gv32), 64'd1);
            check($sformatf("rr_hold[%0d].idx", k), 64'(idx32), 64'd8);
        end
        ack32 = 1'b1;
        tick();
        ack32 = 1'b0;
        check32("rr_hold_rel", 1'b0, 5'd8, 32'h100, 1'b0);
        tick();
        check("rr_hold_idle.valid", 64'(gv32), 64'd0);

        // Pointer now 9: 0x401 picks 10 in round robin
        mode32 = 1'b1; req32 = 32'h0000_0401;
        tick();
        req32 = '0;
        check32("rr_ptr9", 1'b1, 5'd10, 32'h400, 1'b1);

        // Clear beats ack in the same cycle
        clear_n = 1'b0; ack32 = 1'b1;
        tick();
        clear_n = 1'b1; ack32 = 1'b0;
        check32("clear_mid_grant", 1'b0, 5'd0, 32'h0, 1'b0);
        mode32 = 1'b1; req32 = 32'h0000_0006;
        tick();
        req32 = '0;
        check32("post_clear", 1'b1, 5'd1, 32'h2, 1'b1);
        ack32 = 1'b1;
        tick();
        ack32 = 1'b0;

        // Pointer cleared to 0 by reset: 0x401 now picks 0
        clear_n = 1'b0;
        tick();
        clear_n = 1'b1;
        req32 = 32'h0000_0401;
        tick();
        req32 = '0;
        check32("ptr_reset", 1'b1, 5'd0, 32'h1, 1'b1);
        ack32 = 1'b1;
        tick();
        ack32 = 1'b0;

        // N=5 round robin wrap: 0,4,0,4
        mode5 = 1'b1; req5 = 5'b10001;
        for (int k = 0; k < 4; k++) begin
            tick();
            check($sformatf("n5[%0d].valid", k), 64'(gv5), 64'd1);
            check($sformatf("n5[%0d].idx", k), 64'(idx5), (k % 2 == 0) ? 64'd0 : 64'd4);
            check($sformatf("n5[%0d].onehot", k), 64'(oh5), (k % 2 == 0) ? 64'h01 : 64'h10);
            check($sformatf("n5[%0d].err", k), 64'(err5), 64'd1);
            ack5 = 1'b1;
            tick();
            ack5 = 1'b0;
            check($sformatf("n5[%0d].rel", k), 64'(gv5), 64'd0);
        end
        req5 = '0;

        $display("%0d/%0d checks passed", total_checks - failed_checks, total_checks);
        $finish;
    end

endmodule

// File: doc/enc_prio_rr.md
# enc_prio_rr

Parametrised, registered request encoder with arbitration. Converts an N-bit request vector into a binary index plus a one-hot grant, and holds the grant until the consumer acknowledges it. It supports fixed-priority and round-robin modes and flags multi-request conflicts. It sits between the datapath's register-drive request lines and the bus multiplexer select, so several simultaneous drive requests are serialised instead of producing an undefined select.

## Interface
- N, default 32, number of request channels; legal range 2..64; N need not be a power of two.
- W, default $clog2(N), index width; derived localparam, not overridable.

- clock  in  1  rising-edge clock.
- clear_n  in  1  synchronous, active-low reset.
- req  in  N  request vector; bit i requests channel i.
- mode  in  1  0 = fixed priority (lowest index wins); 1 = round-robin.
- ack  in  1  consumer accepts the current grant.
- grant_valid  out  1  grant_idx and grant_onehot are meaningful.
- grant_idx  out  W  binary index of the granted channel.
- grant_onehot  out  N  one-hot copy of the grant.
- err_multi  out  1  one-cycle pulse: more than one req bit was set at the arbitration edge.

## Operation
- All outputs are registered. The reset value of every output is 0. The internal pointer rr_ptr resets to 0, and the FSM resets to IDLE.
- FSM states:
  - IDLE: if req != 0, arbitrate and go to GRANT. Otherwise stay in IDLE.
  - GRANT: hold all grant outputs while ack=0. When ack=1, clear grant_valid at the next edge and return to IDLE.
- Arbitration, mode=0: the winner is the lowest set bit of req. rr_ptr is not modified.
- Arbitration, mode=1: the winner is the first set bit at or above rr_ptr, searching upward and wrapping from N-1 to 0. On ack, rr_ptr <= (grant_idx == N-1) ? 0 : grant_idx+1.
- mode is sampled only at the arbitration edge. Changing mode during GRANT has no effect on the held grant.
- err_multi is 1 for exactly the cycle in which grant_valid first rises, and only if popcount(req) > 1 at the arbitration edge.
- Grants are never revoked. If the granted req bit drops during GRANT, the outputs stay held until ack.
- ack is ignored while grant_valid=0.
- clear_n=0 wins over every other input, including mid-GRANT and including ack in the same cycle.

## Timing
- Latency: req is sampled at edge k, and grant_valid/idx/onehot/err_multi are visible after edge k.
- Release: ack=1 at edge m gives grant_valid=0 after edge m.
- The earliest re-arbitration is at edge m+1, so there is one bubble cycle between consecutive grants. Maximum throughput is one grant per 2 cycles.
- grant_idx and grant_onehot stay stable for the whole time grant_valid=1.
- After a release, grant_idx and grant_onehot keep their last value. Consumers qualify them with grant_valid.
- Reset: clear_n=0 sampled at edge r gives all outputs 0 and rr_ptr=0 after edge r. The first arbitration can happen at the first edge with clear_n=1.

## Structure
- The shared package enc_pkg holds the FSM state enum (IDLE, GRANT) and a clog2 helper function for tools without $clog2.
- Sub-module enc_prio_find is a purely combinational, parametrised lowest-set-bit finder. It outputs the index and a found flag.
  - It is instantiated twice: once on req & mask(rr_ptr) and once on raw req.
  - For round-robin, the masked result is used when found and the raw result otherwise. This gives the wrap-around.
- The top level contains the FSM, the output registers, rr_ptr, and the popcount>1 detection (req & (req-1) != 0).

## Test plan
- N=32, mode=0, req=0x00000001 for one cycle → after the next edge: grant_valid=1, grant_idx=0, grant_onehot=0x1, err_multi=0. Assert ack → grant_valid=0 after that edge.
- N=32, mode=0, req=0x80000010 → grant_idx=4, grant_onehot=0x10, err_multi pulses high for exactly 1 cycle. A second arbitration after ack gives idx=4 again, since fixed priority does not rotate.
- N=32, mode=1, req=0xFFFFFFFF held, ack in every GRANT cycle → grant_idx sequence 0,1,2,…,31,0,1. A new grant arrives every 2 cycles.
- N=32, mode=1, req=0x00000100 then req=0 for 5 cycles with ack=0 → grant_idx=8 and grant_valid=1 are held for all 5 cycles. ack → release, and FSM goes to IDLE with no new grant.
- clear_n=0 while grant_valid=1 with ack=1 in the same cycle → after the edge, all outputs are 0 and rr_ptr=0. Then release clear_n with mode=1, req=0x6 → grant_idx=1.
- N=5, mode=1, req=5'b10001 held, acking each grant → grant_idx sequence 0,4,0,4. This checks wrap from index 4 to 0 for a non-power-of-two N, with W=3.
